// File: rtl/eth_pkt_pkg.sv
// rtl/eth_pkt_pkg.sv - field positions, frame constants, FSM states and length clamp
package eth_pkt_pkg;

  localparam int DST_HI      = 255;
  localparam int DST_LO      = 208;
  localparam int SRC_HI      = 207;
  localparam int SRC_LO      = 160;
  localparam int LEN_HI      = 159;
  localparam int LEN_LO      = 144;

  localparam int PAYLOAD_MIN = 46;
  localparam int PAYLOAD_MAX = 1500;
  localparam int HDR_BYTES   = 14;
  localparam int BUS_BYTES   = 32;

  typedef enum logic [1:0] {IDLE, SOP, DATA, GAP} gen_state_t;

  function automatic logic [10:0] clamp_len(input logic [10:0] len);
    if (len < 11'(PAYLOAD_MIN)) return 11'(PAYLOAD_MIN);
    if (len > 11'(PAYLOAD_MAX)) return 11'(PAYLOAD_MAX);
    return len;
  endfunction

endpackage

// File: rtl/eth_pkt_beat_fmt.sv
// rtl/eth_pkt_beat_fmt.sv - combinational builder for one 32-byte beat of a frame
module eth_pkt_beat_fmt
  import eth_pkt_pkg::*;
(
  input  logic [5:0]   i_beat,
  input  logic [10:0]  i_p,
  input  logic [47:0]  i_dst,
  input  logic [47:0]  i_src,
  output logic [255:0] o_data,
  output logic         o_eop,
  output logic [4:0]   o_empty
);

  logic [10:0]  w_frame;
  logic [5:0]   w_beats;
  logic [255:0] w_hdr;
  logic [10:0]  w_g;

  assign w_frame = i_p + 11'(HDR_BYTES);
  assign w_beats = 6'((w_frame + 11'd31) >> 5);
  assign o_eop   = (i_beat == w_beats - 6'd1);
  // (-F) mod 32 is the unused tail of the last beat, 0 when F fills it exactly
  assign o_empty = 5'(11'd0 - w_frame);

  always_comb begin
    w_hdr                = '0;
    w_hdr[DST_HI:DST_LO] = i_dst;
    w_hdr[SRC_HI:SRC_LO] = i_src;
    w_hdr[LEN_HI:LEN_LO] = {5'b0, i_p};
  end

  always_comb begin
    o_data = '0;
    w_g    = '0;
    for (int b = 0; b < BUS_BYTES; b++) begin
      w_g = {i_beat, 5'(b)};
      if (w_g < 11'(HDR_BYTES))
        o_data[255-8*b -: 8] = w_hdr[255-8*b -: 8];
      else if (w_g < w_frame)
        o_data[255-8*b -: 8] = 8'(w_g - 11'(HDR_BYTES));
    end
  end

endmodule

// File: rtl/eth_pkt_gen.sv
// rtl/eth_pkt_gen.sv - Avalon-ST Ethernet frame generator with start/stop control
// Build option: ETH_PKT_GEN_LEN_SWEEP_EN steps the payload length after every frame.
module eth_pkt_gen
  import eth_pkt_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cfg_start_gen,
  input  logic         cfg_stop_gen,
  input  logic [47:0]  cfg_dst_addr,
  input  logic [47:0]  cfg_src_addr,
  input  logic [10:0]  cfg_pkt_length,
  input  logic [31:0]  cfg_pkt_number,
  input  logic         cfg_continuous,
  input  logic [7:0]   cfg_ipg,
  output logic         stat_gen_compl,
  output logic [31:0]  stat_pkt_cnt,
  output logic [255:0] tx_data,
  output logic         tx_valid,
  output logic         tx_sop,
  output logic         tx_eop,
  output logic [4:0]   tx_empty,
  output logic [5:0]   tx_error,
  input  logic         tx_ready
);

  gen_state_t   r_state, w_nxt_state;
  logic [47:0]  r_dst, r_src;
  logic         r_cont, r_stop;
  logic [7:0]   r_ipg, r_gap;
  logic [31:0]  r_remain;
  logic [10:0]  r_p, w_p_next, w_ld_p;
  logic [5:0]   r_beat, w_ld_beat;
  logic         w_start_req, w_start, w_acc, w_stop_any;
  logic         w_fin_eop, w_fin_gap, w_gap_done, w_load, w_vld_nxt;
  logic [255:0] w_fmt_data;
  logic         w_fmt_eop;
  logic [4:0]   w_fmt_empty;

  assign w_start_req = cfg_start_gen && (r_state == IDLE);
  assign w_start     = w_start_req && (cfg_continuous || (cfg_pkt_number != 32'd0));
  assign w_acc       = tx_valid && tx_ready;
  assign w_stop_any  = r_stop || cfg_stop_gen;
  assign w_fin_eop   = w_stop_any || (!r_cont && (r_remain == 32'd1));
  assign w_fin_gap   = w_stop_any || (!r_cont && (r_remain == 32'd0));
  assign w_gap_done  = (r_gap == r_ipg);
  assign tx_error    = '0;

`ifdef ETH_PKT_GEN_LEN_SWEEP_EN
  assign w_p_next = (r_p == 11'(PAYLOAD_MAX)) ? 11'(PAYLOAD_MIN) : r_p + 11'd1;
`else
  assign w_p_next = clamp_len(cfg_pkt_length);
`endif

  eth_pkt_beat_fmt u_fmt (
    .i_beat  (w_ld_beat),
    .i_p     (w_ld_p),
    .i_dst   (r_dst),
    .i_src   (r_src),
    .o_data  (w_fmt_data),
    .o_eop   (w_fmt_eop),
    .o_empty (w_fmt_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      IDLE:      if (w_start) w_nxt_state = SOP;
      SOP, DATA: if (w_acc) begin
                   if (!tx_eop)               w_nxt_state = DATA;
                   else if (r_ipg != 8'd0)    w_nxt_state = GAP;
                   else if (w_fin_eop)        w_nxt_state = IDLE;
                   else                       w_nxt_state = SOP;
                 end
      GAP:       if (w_gap_done) w_nxt_state = w_fin_gap ? IDLE : SOP;
      default:   w_nxt_state = IDLE;
    endcase
  end

  // Decide which beat (if any) the output register takes at the next edge
  always_comb begin
    w_load    = 1'b0;
    w_ld_beat = r_beat;
    w_ld_p    = r_p;
    w_vld_nxt = tx_valid;
    case (r_state)
      SOP, DATA: begin
        if (!tx_valid) begin
          w_load    = 1'b1;
          w_vld_nxt = 1'b1;
        end else if (w_acc) begin
          if (!tx_eop) begin
            w_load    = 1'b1;
            w_ld_beat = r_beat + 6'd1;
          end else if (w_nxt_state == SOP) begin
            w_load    = 1'b1;
            w_ld_beat = 6'd0;
            w_ld_p    = w_p_next;
          end else begin
            w_vld_nxt = 1'b0;
          end
        end
      end
      GAP: if (w_gap_done && !w_fin_gap) begin
        w_load    = 1'b1;
        w_ld_beat = 6'd0;
        w_ld_p    = w_p_next;
        w_vld_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dst          <= '0;
      r_src          <= '0;
      r_cont         <= 1'b0;
      r_stop         <= 1'b0;
      r_ipg          <= '0;
      r_gap          <= '0;
      r_remain       <= '0;
      r_p            <= '0;
      r_beat         <= '0;
      stat_gen_compl <= 1'b1;
      stat_pkt_cnt   <= '0;
      tx_data        <= '0;
      tx_valid       <= 1'b0;
      tx_sop         <= 1'b0;
      tx_eop         <= 1'b0;
      tx_empty       <= '0;
    end else begin
      stat_gen_compl <= (w_nxt_state == IDLE);
      if (w_start_req)       r_stop <= 1'b0;
      else if (cfg_stop_gen) r_stop <= 1'b1;

      if (w_start) begin
        r_dst        <= cfg_dst_addr;
        r_src        <= cfg_src_addr;
        r_cont       <= cfg_continuous;
        r_ipg        <= cfg_ipg;
        r_remain     <= cfg_pkt_number;
        r_p          <= clamp_len(cfg_pkt_length);
        r_beat       <= '0;
        stat_pkt_cnt <= '0;
      end else begin
        if (w_load) begin
          r_p    <= w_ld_p;
          r_beat <= w_ld_beat;
        end
        if (w_acc && tx_eop) begin
          stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
          r_remain     <= r_remain - 32'd1;
        end
      end

      if (w_acc && tx_eop)                    r_gap <= 8'd1;
      else if (r_state == GAP && !w_gap_done) r_gap <= r_gap + 8'd1;

      tx_valid <= w_vld_nxt;
      if (w_load) begin
        tx_data  <= w_fmt_data;
        tx_sop   <= (w_ld_beat == 6'd0);
        tx_eop   <= w_fmt_eop;
        tx_empty <= w_fmt_empty;
      end else if (!w_vld_nxt) begin
        tx_sop <= 1'b0;
        tx_eop <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_pkt_gen.sv
// tb/tb_eth_pkt_gen.sv - directed self-checking bench for eth_pkt_gen
module tb_eth_pkt_gen;

  localparam logic [47:0] DST = 48'hA1A2_A3A4_A5A6;
  localparam logic [47:0] SRC = 48'hB1B2_B3B4_B5B6;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cfg_start_gen, cfg_stop_gen, cfg_continuous;
  logic [47:0]  cfg_dst_addr, cfg_src_addr;
  logic [10:0]  cfg_pkt_length;
  logic [31:0]  cfg_pkt_number;
  logic [7:0]   cfg_ipg;
  logic         stat_gen_compl;
  logic [31:0]  stat_pkt_cnt;
  logic [255:0] tx_data;
  logic         tx_valid, tx_sop, tx_eop, tx_ready;
  logic [4:0]   tx_empty;
  logic [5:0]   tx_error;
  logic         rnd_ready;

  int n_chk  = 0;
  int n_pass = 0;
  int mon_pkts = 0, mon_sops = 0, hold_err = 0;
  int rec_beats[32], rec_empty[32], rec_len[32], rec_err[32], rec_gap[32];
  int exp_p[32];
  int base, sb;

  always #5 clk = ~clk;

  eth_pkt_gen dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_start_gen(cfg_start_gen), .cfg_stop_gen(cfg_stop_gen),
    .cfg_dst_addr(cfg_dst_addr), .cfg_src_addr(cfg_src_addr),
    .cfg_pkt_length(cfg_pkt_length), .cfg_pkt_number(cfg_pkt_number),
    .cfg_continuous(cfg_continuous), .cfg_ipg(cfg_ipg),
    .stat_gen_compl(stat_gen_compl), .stat_pkt_cnt(stat_pkt_cnt),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_empty(tx_empty), .tx_error(tx_error), .tx_ready(tx_ready)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] ref_byte(input int g, input int p);
    if (g >= 14 + p) return 8'h00;
    if (g < 6)       return 8'(DST >> (8 * (5 - g)));
    if (g < 12)      return 8'(SRC >> (8 * (11 - g)));
    if (g == 12)     return 8'(p >> 8);
    if (g == 13)     return 8'(p);
    return 8'(g - 14);
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_exp(input int b, input int n, input int p);
    for (int i = 0; i < n; i++) exp_p[(b + i) % 32] = p;
  endtask

  task automatic start(input int len, input int num, input logic cont, input int ipg, input logic stop);
    cfg_pkt_length = 11'(len);
    cfg_pkt_number = 32'(num);
    cfg_continuous = cont;
    cfg_ipg        = 8'(ipg);
    cfg_start_gen  = 1'b1;
    cfg_stop_gen   = stop;
    cyc(1);
    cfg_start_gen  = 1'b0;
    cfg_stop_gen   = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (stat_gen_compl !== 1'b1 && n < max) begin cyc(1); n++; end
    chk("idle_timeout", n < max, 1'b1);
  endtask

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Beat monitor: byte-level reference, per-frame records, stall stability
  initial begin
    int cur_beats, cur_err, cur_idle, cur_len;
    logic prev_stall;
    logic [263:0] snap, prev_snap;
    cur_beats = 0; cur_err = 0; cur_idle = 0; cur_len = 0;
    prev_stall = 1'b0; prev_snap = '0;
    forever begin
      @(negedge clk);
      snap = {tx_valid, tx_sop, tx_eop, tx_empty, tx_data};
      if (!reset_n) begin
        cur_beats = 0; cur_err = 0; cur_idle = 0; prev_stall = 1'b0;
      end else begin
        if (prev_stall && snap !== prev_snap) hold_err++;
        prev_snap  = snap;
        prev_stall = tx_valid && !tx_ready;
        if (!tx_valid) cur_idle++;
        if (tx_valid && tx_ready) begin
          if (tx_sop) begin
            mon_sops++;
            rec_gap[mon_pkts % 32] = cur_idle;
            cur_beats = 0;
            cur_err   = 0;
            cur_len   = int'(tx_data[159:144]);
          end
          for (int b = 0; b < 32; b++)
            if (tx_data[255-8*b -: 8] !== ref_byte(cur_beats * 32 + b, exp_p[mon_pkts % 32])) cur_err++;
          cur_beats++;
          if (tx_eop) begin
            rec_beats[mon_pkts % 32] = cur_beats;
            rec_empty[mon_pkts % 32] = int'(tx_empty);
            rec_len[mon_pkts % 32]   = cur_len;
            rec_err[mon_pkts % 32]   = cur_err;
            mon_pkts++;
            cur_idle = 0;
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; rnd_ready = 1'b0;
    cfg_start_gen = 1'b0; cfg_stop_gen = 1'b0; cfg_continuous = 1'b0;
    cfg_dst_addr = DST; cfg_src_addr = SRC;
    cfg_pkt_length = 11'd46; cfg_pkt_number = 32'd1; cfg_ipg = 8'd0;
    cyc(3);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_sop_eop", {tx_sop, tx_eop}, 2'b00);
    chk("rst_data", tx_data, 256'd0);
    chk("rst_empty", tx_empty, 5'd0);
    chk("rst_error", tx_error, 6'd0);
    chk("rst_compl", stat_gen_compl, 1'b1);
    chk("rst_cnt", stat_pkt_cnt, 32'd0);
    reset_n = 1'b1;
    cyc(2);

    // Minimum frame: F=60, 2 beats, empty 4
    base = mon_pkts; set_exp(base, 1, 46);
    start(46, 1, 1'b0, 0, 1'b0);
    chk("lat_n1_valid", tx_valid, 1'b0);
    chk("compl_busy", stat_gen_compl, 1'b0);
    cyc(1);
    chk("lat_n2_sop", {tx_valid, tx_sop}, 2'b11);
    chk("sop_len", tx_data[159:144], 16'h002E);
    chk("sop_dst", tx_data[255:208], DST);
    chk("sop_src", tx_data[207:160], SRC);
    wait_idle(200);
    chk("t1_pkts", mon_pkts - base, 1);
    chk("t1_beats", rec_beats[base % 32], 2);
    chk("t1_empty", rec_empty[base % 32], 4);
    chk("t1_bytes", rec_err[base % 32], 0);
    chk("t1_cnt", stat_pkt_cnt, 32'd1);

    // Maximum frame: F=1514, 48 beats, empty 1536-1514=22, ipg 4
    base = mon_pkts; set_exp(base, 3, 1500);
    start(1500, 3, 1'b0, 4, 1'b0);
    wait_idle(1000);
    chk("t2_pkts", mon_pkts - base, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_beats", rec_beats[(base + i) % 32], 48);
      chk("t2_empty", rec_empty[(base + i) % 32], 22);
      chk("t2_bytes", rec_err[(base + i) % 32], 0);
      if (i > 0) chk("t2_gap", rec_gap[(base + i) % 32], 4);
    end
    chk("t2_cnt", stat_pkt_cnt, 32'd3);

    // F=64 exactly two full beats, random backpressure
    rnd_ready = 1'b1;
    base = mon_pkts; set_exp(base, 1, 50);
    start(50, 1, 1'b0, 0, 1'b0);
    wait_idle(500);
    rnd_ready = 1'b0;
    cyc(2);
    chk("t3_beats", rec_beats[base % 32], 2);
    chk("t3_empty", rec_empty[base % 32], 0);
    chk("t3_bytes", rec_err[base % 32], 0);
    chk("t3_hold", hold_err, 0);
    chk("t3_cnt", stat_pkt_cnt, 32'd1);

    // Continuous, stop during the third frame (7 beats each)
    base = mon_pkts; sb = mon_sops; set_exp(base, 8, 200);
    start(200, 0, 1'b1, 0, 1'b0);
    begin
      int n;
      n = 0;
      while (mon_pkts < base + 2 && n < 200) begin cyc(1); n++; end
      chk("t4_timeout", n < 200, 1'b1);
    end
    cyc(3);
    cfg_stop_gen = 1'b1;
    cyc(1);
    cfg_stop_gen = 1'b0;
    wait_idle(200);
    cyc(20);
    chk("t4_cnt", stat_pkt_cnt, 32'd3);
    chk("t4_pkts", mon_pkts - base, 3);
    chk("t4_sops", mon_sops - sb, 3);
    chk("t4_bytes", rec_err[(base + 2) % 32], 0);
    chk("t4_compl", {stat_gen_compl, tx_valid}, 2'b10);

    // Start and stop in the same cycle: start wins
    base = mon_pkts; set_exp(base, 2, 46);
    start(46, 2, 1'b0, 0, 1'b1);
    wait_idle(200);
    chk("t5_cnt", stat_pkt_cnt, 32'd2);
    chk("t5_pkts", mon_pkts - base, 2);

    // Clamping of out-of-range lengths
    base = mon_pkts; set_exp(base, 1, 46);
    start(10, 1, 1'b0, 0, 1'b0);
    wait_idle(200);
    chk("t6_len_lo", rec_len[base % 32], 46);
    chk("t6_bytes_lo", rec_err[base % 32], 0);
    base = mon_pkts; set_exp(base, 1, 1500);
    start(2000, 1, 1'b0, 0, 1'b0);
    wait_idle(400);
    chk("t6_len_hi", rec_len[base % 32], 1500);
    chk("t6_beats_hi", rec_beats[base % 32], 48);

    // Reset in the middle of a frame
    base = mon_pkts; set_exp(base, 1, 1500);
    start(1500, 1, 1'b0, 0, 1'b0);
    cyc(5);
    chk("t7_running", tx_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t7_valid", {tx_valid, tx_sop, tx_eop}, 3'b000);
    chk("t7_data", tx_data, 256'd0);
    chk("t7_empty", tx_empty, 5'd0);
    chk("t7_cnt_compl", {stat_pkt_cnt, stat_gen_compl}, {32'd0, 1'b1});
    cyc(2);
    reset_n = 1'b1;
    cyc(2);

`ifdef ETH_PKT_GEN_LEN_SWEEP_EN
    base = mon_pkts;
    exp_p[base % 32] = 1499; exp_p[(base + 1) % 32] = 1500; exp_p[(base + 2) % 32] = 46;
    start(1499, 3, 1'b0, 0, 1'b0);
    wait_idle(600);
    chk("sw_len0", rec_len[base % 32], 1499);
    chk("sw_len1", rec_len[(base + 1) % 32], 1500);
    chk("sw_len2", rec_len[(base + 2) % 32], 46);
    chk("sw_bytes", rec_err[(base + 2) % 32], 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
